// File: rtl/decoder_pkg.sv
// Shared definitions for the ID stage of the pipelined MIPS core.
// Holds the opcode and funct encodings, the alucontrol codes and ctrl_t,
// the control bundle stored in the ID/EX register.
package decoder_pkg;

  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_REGIMM = 6'b000001;  // bltz
  localparam logic [5:0] OP_J      = 6'b000010;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_ADDIU  = 6'b001001;
  localparam logic [5:0] OP_ORI    = 6'b001101;
  localparam logic [5:0] OP_LUI    = 6'b001111;
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_SW     = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100001;
  localparam logic [5:0] FN_SUB = 6'b100011;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101011;

  localparam logic [2:0] ALU_ADD = 3'b101;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b111;
  localparam logic [2:0] ALU_OR  = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b000;
  localparam logic [2:0] ALU_NOP = 3'b011;

  typedef struct packed {
    logic       regwrite;
    logic       memwrite;
    logic       memtoreg;
    logic       alusrcbimm;
    logic       dojump;
    logic       lui;
    logic       br_eq;
    logic       br_ltz;
    logic       illegal;
    logic [2:0] alucontrol;
    logic [4:0] destreg;
  } ctrl_t;

  // Empty slot in the ID/EX register: no side effects, ALU idle.
  function automatic ctrl_t ctrl_bubble();
    ctrl_t c;
    c            = '0;
    c.alucontrol = ALU_NOP;
    return c;
  endfunction

endpackage

// File: rtl/decoder_core.sv
// Purely combinational instruction decoder.
// Ports:
//   instr    in  32  instruction word
//   ctrl     out     decoded control bundle (illegal encodings give a safe, all-off bundle)
//   reads_rs out 1   instruction reads the register named in instr[25:21]
//   reads_rt out 1   instruction reads the register named in instr[20:16]
module decoder_core
  import decoder_pkg::*;
#(
  parameter int unsigned EN_EXT_OPS = 1
) (
  input  logic [31:0] instr,
  output ctrl_t       ctrl,
  output logic        reads_rs,
  output logic        reads_rt
);

  logic [5:0] op;
  logic [5:0] funct;
  logic       ext_ok;
  logic       unused_fields;

  assign op            = instr[31:26];
  assign funct         = instr[5:0];
  assign ext_ok        = (EN_EXT_OPS != 0);
  assign unused_fields = ^{instr[25:21], instr[10:6]};

  // Source usage is a property of the opcode alone; hazard detection uses it
  // even for encodings that turn out illegal.
  assign reads_rs = (op != OP_J) && (op != OP_LUI);
  assign reads_rt = (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_SW);

  always_comb begin
    ctrl            = '0;
    ctrl.alucontrol = ALU_NOP;
    case (op)
      OP_RTYPE: begin
        ctrl.regwrite = 1'b1;
        ctrl.destreg  = instr[15:11];
        case (funct)
          FN_ADD:  ctrl.alucontrol = ALU_ADD;
          FN_SUB:  ctrl.alucontrol = ALU_SUB;
          FN_AND:  ctrl.alucontrol = ALU_AND;
          FN_OR:   ctrl.alucontrol = ALU_OR;
          FN_SLT:  ctrl.alucontrol = ALU_SLT;
          default: ctrl.illegal    = 1'b1;
        endcase
      end
      OP_LW: begin
        ctrl.regwrite   = 1'b1;
        ctrl.memtoreg   = 1'b1;
        ctrl.alusrcbimm = 1'b1;
        ctrl.alucontrol = ALU_ADD;
        ctrl.destreg    = instr[20:16];
      end
      OP_SW: begin
        ctrl.memwrite   = 1'b1;
        ctrl.alusrcbimm = 1'b1;
        ctrl.alucontrol = ALU_ADD;
      end
      OP_BEQ: begin
        ctrl.br_eq      = 1'b1;
        ctrl.alucontrol = ALU_SUB;
      end
      OP_ADDIU: begin
        ctrl.regwrite   = 1'b1;
        ctrl.alusrcbimm = 1'b1;
        ctrl.alucontrol = ALU_ADD;
        ctrl.destreg    = instr[20:16];
      end
      OP_J: ctrl.dojump = 1'b1;
      OP_LUI: begin
        ctrl.regwrite = 1'b1;
        ctrl.lui      = 1'b1;
        ctrl.destreg  = instr[20:16];
        ctrl.illegal  = ~ext_ok;
      end
      OP_ORI: begin
        ctrl.regwrite   = 1'b1;
        ctrl.alusrcbimm = 1'b1;
        ctrl.alucontrol = ALU_OR;
        ctrl.destreg    = instr[20:16];
        ctrl.illegal    = ~ext_ok;
      end
      OP_REGIMM: begin
        ctrl.br_ltz     = 1'b1;
        ctrl.alucontrol = ALU_SLT;
        ctrl.illegal    = ~ext_ok;
      end
      default: ctrl.illegal = 1'b1;
    endcase
    // Anything undecodable must not touch architectural state.
    if (ctrl.illegal) begin
      ctrl         = ctrl_bubble();
      ctrl.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/pipelined_decoder.sv
// Registered ID stage: one instruction per cycle into the ID/EX register.
// Ports:
//   clk, reset_n            clock, synchronous active-low reset
//   in_valid/in_ready/instr instruction handshake from IF
//   flush                   redirect from EX, empties the ID/EX register
//   out_valid/out_ready     control bundle handshake toward EX
//   rs, rt, imm, jtarget    raw instruction fields of the held instruction
//   destreg + control bits  decoded bundle (br_eq/br_ltz resolved in EX)
//   illegal                 held instruction was undecodable
//   stall_count             saturating count of load-use bubbles
// Handshake: a transfer happens on an edge where valid and ready are both 1.
// out_valid, once 1, holds with the bundle stable until out_ready (or flush/reset).
module pipelined_decoder
  import decoder_pkg::*;
#(
  parameter int unsigned REG_ADDR_W  = 5,
  parameter int unsigned ALUCTRL_W   = 3,
  parameter int unsigned EN_EXT_OPS  = 1,
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            instr,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [REG_ADDR_W-1:0]  rs,
  output logic [REG_ADDR_W-1:0]  rt,
  output logic [15:0]            imm,
  output logic [25:0]            jtarget,
  output logic [REG_ADDR_W-1:0]  destreg,
  output logic                   regwrite,
  output logic                   memwrite,
  output logic                   memtoreg,
  output logic                   alusrcbimm,
  output logic                   dojump,
  output logic                   lui,
  output logic                   br_eq,
  output logic                   br_ltz,
  output logic [ALUCTRL_W-1:0]   alucontrol,
  output logic                   illegal,
  output logic [STALL_CNT_W-1:0] stall_count
);

  ctrl_t dec;
  logic  dec_reads_rs;
  logic  dec_reads_rt;

  decoder_core #(.EN_EXT_OPS(EN_EXT_OPS)) u_core (
    .instr    (instr),
    .ctrl     (dec),
    .reads_rs (dec_reads_rs),
    .reads_rt (dec_reads_rt)
  );

  logic                   valid_q, valid_d;
  ctrl_t                  ctrl_q, ctrl_d;
  logic [25:0]            fields_q, fields_d;
  logic [STALL_CNT_W-1:0] stall_q, stall_d;
  logic                   adv, hazard, accept, src_match;

  always_comb begin
    adv       = ~valid_q | out_ready;
    src_match = (dec_reads_rs && (instr[25:21] == ctrl_q.destreg)) ||
                (dec_reads_rt && (instr[20:16] == ctrl_q.destreg));
    // Only a held load can create a load-use hazard; a bubble never does.
    hazard    = valid_q & ctrl_q.memtoreg & ctrl_q.regwrite &
                (ctrl_q.destreg != '0) & in_valid & src_match;
    // During flush the offered instruction is consumed and thrown away.
    in_ready  = reset_n & (flush | (adv & ~hazard));
    accept    = in_valid & in_ready & ~flush;

    valid_d  = valid_q;
    ctrl_d   = ctrl_q;
    fields_d = fields_q;
    stall_d  = stall_q;
    if (flush) begin
      valid_d  = 1'b0;
      ctrl_d   = ctrl_bubble();
      fields_d = '0;
    end else if (adv) begin
      valid_d  = accept;
      ctrl_d   = accept ? dec : ctrl_bubble();
      fields_d = accept ? instr[25:0] : '0;
      if (hazard && (stall_q != '1)) stall_d = stall_q + STALL_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_q  <= 1'b0;
      ctrl_q   <= ctrl_bubble();
      fields_q <= '0;
      stall_q  <= '0;
    end else begin
      valid_q  <= valid_d;
      ctrl_q   <= ctrl_d;
      fields_q <= fields_d;
      stall_q  <= stall_d;
    end
  end

  assign out_valid   = valid_q;
  assign rs          = REG_ADDR_W'(fields_q[25:21]);
  assign rt          = REG_ADDR_W'(fields_q[20:16]);
  assign imm         = fields_q[15:0];
  assign jtarget     = fields_q;
  assign destreg     = REG_ADDR_W'(ctrl_q.destreg);
  assign regwrite    = ctrl_q.regwrite;
  assign memwrite    = ctrl_q.memwrite;
  assign memtoreg    = ctrl_q.memtoreg;
  assign alusrcbimm  = ctrl_q.alusrcbimm;
  assign dojump      = ctrl_q.dojump;
  assign lui         = ctrl_q.lui;
  assign br_eq       = ctrl_q.br_eq;
  assign br_ltz      = ctrl_q.br_ltz;
  assign alucontrol  = ALUCTRL_W'(ctrl_q.alucontrol);
  assign illegal     = ctrl_q.illegal;
  assign stall_count = stall_q;

endmodule

// File: tb/tb_pipelined_decoder.sv
// Bench for pipelined_decoder: two instances share all inputs, one with the
// extended opcodes enabled and one without; both are compared each cycle
// against a behavioural model of the ID stage.
module tb_pipelined_decoder;

  localparam int SCW = 4;

  // ---------------- clock / reset / inputs ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, in_valid, flush, out_ready;
  logic [31:0] instr;

  // ---------------- DUT outputs (index 0: ext ops on, 1: off) ----------------
  logic           in_ready_o [2];
  logic           out_valid_o[2];
  logic [4:0]     rs_o[2], rt_o[2], destreg_o[2];
  logic [15:0]    imm_o[2];
  logic [25:0]    jtarget_o[2];
  logic           regwrite_o[2], memwrite_o[2], memtoreg_o[2], alusrcbimm_o[2];
  logic           dojump_o[2], lui_o[2], br_eq_o[2], br_ltz_o[2], illegal_o[2];
  logic [2:0]     alu_o[2];
  logic [SCW-1:0] stall_o[2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    pipelined_decoder #(
      .REG_ADDR_W(5), .ALUCTRL_W(3), .EN_EXT_OPS((g == 0) ? 1 : 0), .STALL_CNT_W(SCW)
    ) u_dut (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_o[g]),
      .instr(instr), .flush(flush), .out_valid(out_valid_o[g]), .out_ready(out_ready),
      .rs(rs_o[g]), .rt(rt_o[g]), .imm(imm_o[g]), .jtarget(jtarget_o[g]),
      .destreg(destreg_o[g]), .regwrite(regwrite_o[g]), .memwrite(memwrite_o[g]),
      .memtoreg(memtoreg_o[g]), .alusrcbimm(alusrcbimm_o[g]), .dojump(dojump_o[g]),
      .lui(lui_o[g]), .br_eq(br_eq_o[g]), .br_ltz(br_ltz_o[g]), .alucontrol(alu_o[g]),
      .illegal(illegal_o[g]), .stall_count(stall_o[g])
    );
  end

  // ---------------- reference model ----------------
  typedef struct packed {
    logic rw, mw, mtr, asi, dj, lu, beq, bltz, ill;
    logic [2:0] alu;
    logic [4:0] dst;
  } exp_t;

  // Decode table written straight from the instruction set description.
  function automatic exp_t ref_dec(input logic [31:0] ins, input bit en);
    exp_t e;
    logic [5:0] op, fn;
    op = ins[31:26];
    fn = ins[5:0];
    e = '0;
    e.alu = 3'b011;
    if (op == 6'h00) begin
      e.rw = 1; e.dst = ins[15:11];
      if      (fn == 6'h21) e.alu = 3'b101;
      else if (fn == 6'h23) e.alu = 3'b001;
      else if (fn == 6'h24) e.alu = 3'b111;
      else if (fn == 6'h25) e.alu = 3'b110;
      else if (fn == 6'h2B) e.alu = 3'b000;
      else e.ill = 1;
    end else if (op == 6'h23) begin
      e.rw = 1; e.mtr = 1; e.asi = 1; e.alu = 3'b101; e.dst = ins[20:16];
    end else if (op == 6'h2B) begin
      e.mw = 1; e.asi = 1; e.alu = 3'b101;
    end else if (op == 6'h04) begin
      e.beq = 1; e.alu = 3'b001;
    end else if (op == 6'h09) begin
      e.rw = 1; e.asi = 1; e.alu = 3'b101; e.dst = ins[20:16];
    end else if (op == 6'h02) begin
      e.dj = 1;
    end else if (op == 6'h0F && en) begin
      e.rw = 1; e.lu = 1; e.dst = ins[20:16];
    end else if (op == 6'h0D && en) begin
      e.rw = 1; e.asi = 1; e.alu = 3'b110; e.dst = ins[20:16];
    end else if (op == 6'h01 && en) begin
      e.bltz = 1; e.alu = 3'b000;
    end else begin
      e.ill = 1;
    end
    if (e.ill) begin
      e = '0; e.ill = 1; e.alu = 3'b011;
    end
    return e;
  endfunction

  function automatic bit reads_reg(input logic [31:0] ins, input logic [4:0] r);
    logic [5:0] op;
    bit rs_used, rt_used;
    op = ins[31:26];
    rs_used = (op != 6'h02) && (op != 6'h0F);
    rt_used = (op == 6'h00) || (op == 6'h04) || (op == 6'h2B);
    return (rs_used && ins[25:21] == r) || (rt_used && ins[20:16] == r);
  endfunction

  bit          m_valid = 0, m_clear = 0;
  logic [31:0] m_instr = '0;
  int          m_stall = 0;

  // ---------------- scoreboard counters ----------------
  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check current outputs against the model, then advance model and clock.
  task automatic step();
    bit   adv, hz, rdy;
    exp_t e;
    @(negedge clk);
    adv = !m_valid || out_ready;
    hz  = m_valid && m_instr[31:26] == 6'h23 && m_instr[20:16] != 5'd0 &&
          in_valid && reads_reg(instr, m_instr[20:16]);
    rdy = reset_n && (flush || (adv && !hz));
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("d%0d_in_ready", g), 32'(in_ready_o[g]), 32'(rdy));
      chk($sformatf("d%0d_out_valid", g), 32'(out_valid_o[g]), 32'(m_valid));
      chk($sformatf("d%0d_stall", g), 32'(stall_o[g]), 32'(m_stall));
      if (m_valid) begin
        e = ref_dec(m_instr, g == 0);
        chk($sformatf("d%0d_ctrl", g),
            32'({regwrite_o[g], memwrite_o[g], memtoreg_o[g], alusrcbimm_o[g], dojump_o[g],
                 lui_o[g], br_eq_o[g], br_ltz_o[g], illegal_o[g]}),
            32'({e.rw, e.mw, e.mtr, e.asi, e.dj, e.lu, e.beq, e.bltz, e.ill}));
        chk($sformatf("d%0d_alu", g), 32'(alu_o[g]), 32'(e.alu));
        chk($sformatf("d%0d_destreg", g), 32'(destreg_o[g]), 32'(e.dst));
        chk($sformatf("d%0d_fields", g), {rs_o[g], rt_o[g], imm_o[g]}, 32'(m_instr[25:0]) << 0);
        chk($sformatf("d%0d_jtarget", g), 32'(jtarget_o[g]), 32'(m_instr[25:0]));
      end else if (m_clear) begin
        chk($sformatf("d%0d_cleared_ctrl", g),
            32'({regwrite_o[g], memwrite_o[g], memtoreg_o[g], alusrcbimm_o[g], dojump_o[g],
                 lui_o[g], br_eq_o[g], br_ltz_o[g], illegal_o[g], destreg_o[g]}), 32'd0);
        chk($sformatf("d%0d_cleared_alu", g), 32'(alu_o[g]), 32'd3);
      end
    end
    if (!reset_n) begin
      m_valid = 0; m_stall = 0; m_clear = 1;
    end else if (flush) begin
      m_valid = 0; m_clear = 1;
    end else if (adv) begin
      if (hz && m_stall < (1 << SCW) - 1) m_stall++;
      if (in_valid && rdy) begin
        m_valid = 1; m_instr = instr; m_clear = 0;
      end else begin
        m_valid = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- random instruction source ----------------
  logic [5:0] ops[10] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h09, 6'h02, 6'h0F, 6'h0D, 6'h01, 6'h3F};
  logic [5:0] fns[6]  = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h2B, 6'h20};

  function automatic logic [31:0] rand_instr();
    int sel;
    logic [4:0] a, b, d;
    sel = $urandom_range(0, 12);
    a = 5'($urandom_range(0, 3));
    b = 5'($urandom_range(0, 3));
    d = 5'($urandom_range(0, 3));
    if (sel >= 10) return {6'h23, a, b, 16'($urandom)};  // extra loads for hazards
    if (sel == 0) return {6'h00, a, b, d, 5'd0, fns[$urandom_range(0, 5)]};
    return {ops[sel], a, b, 16'($urandom)};
  endfunction

  // ---------------- directed then random sequence ----------------
  initial begin
    reset_n = 0; in_valid = 0; flush = 0; out_ready = 1; instr = '0;
    @(posedge clk); #1;
    m_clear = 1;
    step();                                   // reset state checks

    // addu $3,$1,$2
    reset_n = 1; in_valid = 1; instr = 32'h00221821;
    step();
    chk("t1_out_valid", 32'(out_valid_o[0]), 32'd1);
    chk("t1_destreg", 32'(destreg_o[0]), 32'd3);
    chk("t1_alu", 32'(alu_o[0]), 32'b101);
    chk("t1_regwrite", 32'(regwrite_o[0]), 32'd1);

    // lw $2,0($1) then dependent addu $4,$2,$3
    instr = 32'h8C220000; step();
    instr = 32'h00432021; step();             // bubble, in_ready low
    chk("t2_bubble", 32'(out_valid_o[0]), 32'd0);
    step();                                   // now accepted
    chk("t2_stall_count", 32'(stall_o[0]), 32'd1);

    // sw held while EX is not ready
    instr = 32'hAC220004; step();
    out_ready = 0; instr = 32'h00221821;
    for (int i = 0; i < 3; i++) step();
    chk("t3_memwrite", 32'(memwrite_o[0]), 32'd1);
    out_ready = 1; step();

    // flush while beq is offered
    flush = 1; instr = 32'h10220003; step();
    chk("t4_flushed", 32'(out_valid_o[0]), 32'd0);
    flush = 0; in_valid = 0; step();

    // illegal opcode, then lui with and without the extended set
    in_valid = 1; instr = 32'hFC000000; step();
    chk("t5_illegal_d0", 32'(illegal_o[0]), 32'd1);
    chk("t5_illegal_d1", 32'(illegal_o[1]), 32'd1);
    instr = 32'h3C011234; step();
    chk("t5_lui_illegal_d1", 32'(illegal_o[1]), 32'd1);
    chk("t5_lui_alu_d1", 32'(alu_o[1]), 32'b011);
    chk("t5_lui_regwrite_d1", 32'(regwrite_o[1]), 32'd0);
    chk("t5_lui_legal_d0", 32'(lui_o[0]), 32'd1);

    // drive the stall counter into saturation
    for (int i = 0; i < 20; i++) begin
      instr = 32'h8C010000; step();           // lw $1
      instr = 32'h00211021; step(); step();   // addu $2,$1,$1
    end
    chk("t6_saturated", 32'(stall_o[0]), 32'((1 << SCW) - 1));
    instr = 32'h8C010000; step();
    instr = 32'h00211021; reset_n = 0; step(); // reset during a pending stall
    chk("t6_reset_valid", 32'(out_valid_o[0]), 32'd0);
    chk("t6_reset_stall", 32'(stall_o[0]), 32'd0);
    reset_n = 1;

    for (int i = 0; i < 800; i++) begin
      reset_n   = ($urandom_range(0, 99) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      instr     = rand_instr();
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
